// File: rtl/spi_fsm.sv
// spi_fsm: transaction controller for the SPI memory.
//
// Sequences one transaction made of two WIDTH-bit frames. The first frame carries the address in
// [WIDTH-1:1] and the R/W flag in bit 0 (1 = read). The second frame carries the data. Each
// transaction drives address capture, then either a memory write or a read-back load into the
// shift register, and enables the MISO buffer while read data is shifted out.
//
// Ports:
//   i_clk          FPGA clock; all logic on its rising edge
//   i_reset_n      synchronous active-low reset
//   i_cs_cond      conditioned chip select, active low
//   i_sclk_pos     one-clk pulse per conditioned SCLK rising edge
//   i_shift_reg_p  shift register parallel output
//   o_addr_we      address latch write enable
//   o_dm_we        data memory write enable
//   o_sr_we        shift register parallel-load enable
//   o_miso_buff    MISO tri-state enable (1 = drive)
//   o_dbg_state    state code for debug LEDs
//
// Build option: define SPI_FSM_DEBUG_EN to drive o_dbg_state from a registered copy of the
// state code. Without it, o_dbg_state is tied to 3'b000.

module spi_fsm #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_cs_cond,
   input  logic             i_sclk_pos,
   input  logic [WIDTH-1:0] i_shift_reg_p,
   output logic             o_addr_we,
   output logic             o_dm_we,
   output logic             o_sr_we,
   output logic             o_miso_buff,
   output logic [2:0]       o_dbg_state
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      StIdle        = 3'd0,
      StGetAddr     = 3'd1,
      StGotAddr     = 3'd2,
      StReadLoad    = 3'd3,
      StReadShift   = 3'd4,
      StWriteGet    = 3'd5,
      StWriteCommit = 3'd6,
      StDone        = 3'd7
   } state_e;

   state_e            r_state;
   state_e            w_state_d;
   logic [CntW-1:0]   r_cnt;
   logic [CntW-1:0]   w_cnt_d;
   logic              w_last_pulse;
   logic              r_addr_we;
   logic              r_dm_we;
   logic              r_sr_we;
   logic              r_miso_buff;
   logic              w_unused;

   // Only the R/W flag is decoded here; the rest of the frame goes to the address latch and memory.
   assign w_unused     = ^i_shift_reg_p[WIDTH-1:1];
   assign w_last_pulse = i_sclk_pos && (r_cnt == CntW'(WIDTH - 1));

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      case (r_state)
         StIdle: begin
            if (!i_cs_cond) w_state_d = StGetAddr;
         end
         StGetAddr, StReadShift, StWriteGet: begin
            if (w_last_pulse) begin
               case (r_state)
                  StGetAddr:   w_state_d = StGotAddr;
                  StReadShift: w_state_d = StDone;
                  default:     w_state_d = StWriteCommit;
               endcase
            end else if (i_sclk_pos) begin
               w_cnt_d = r_cnt + CntW'(1);
            end
         end
         StGotAddr: begin
            w_state_d = i_shift_reg_p[0] ? StReadLoad : StWriteGet;
         end
         StReadLoad:    w_state_d = StReadShift;
         StWriteCommit: w_state_d = StDone;
         StDone:        w_state_d = StDone;
         default:       w_state_d = StIdle;
      endcase
      // CS release aborts from anywhere, overriding a same-cycle final pulse or pending commit.
      if (r_state != StIdle && i_cs_cond) w_state_d = StIdle;
      if (w_state_d != r_state) w_cnt_d = '0;
   end

   // Outputs are decoded from the next state and registered so they line up with the state.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_addr_we   <= 1'b0;
         r_dm_we     <= 1'b0;
         r_sr_we     <= 1'b0;
         r_miso_buff <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_addr_we   <= (w_state_d == StGotAddr);
         r_dm_we     <= (w_state_d == StWriteCommit);
         r_sr_we     <= (w_state_d == StReadLoad);
         r_miso_buff <= (w_state_d == StReadLoad) || (w_state_d == StReadShift);
      end
   end

   assign o_addr_we   = r_addr_we;
   assign o_dm_we     = r_dm_we;
   assign o_sr_we     = r_sr_we;
   assign o_miso_buff = r_miso_buff;

`ifdef SPI_FSM_DEBUG_EN
   logic [2:0] r_dbg_state;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_dbg_state <= 3'd0;
      end else begin
         r_dbg_state <= w_state_d;
      end
   end

   assign o_dbg_state = r_dbg_state;
`else
   assign o_dbg_state = 3'b000;
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: self-checking bench for spi_fsm.
//
// A table of single-cycle vectors walks a write, a read and an address-phase abort with
// back-to-back pulses. Hand-written sequences then use pulses 8 clks apart for the write, read,
// abort-after-12, simultaneous CS/final-pulse and mid-read reset cases. Set SPI_FSM_DEBUG_EN
// to also check o_dbg_state against the state codes.

module tb_spi_fsm;

   logic       clk;
   logic       reset_n;
   logic       cs_cond;
   logic       sclk_pos;
   logic [7:0] shift_reg_p;
   logic       addr_we;
   logic       dm_we;
   logic       sr_we;
   logic       miso_buff;
   logic [2:0] dbg_state;

   spi_fsm #(
      .WIDTH(8)
   ) u_dut (
      .i_clk         (clk),
      .i_reset_n     (reset_n),
      .i_cs_cond     (cs_cond),
      .i_sclk_pos    (sclk_pos),
      .i_shift_reg_p (shift_reg_p),
      .o_addr_we     (addr_we),
      .o_dm_we       (dm_we),
      .o_sr_we       (sr_we),
      .o_miso_buff   (miso_buff),
      .o_dbg_state   (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       cs;
      logic       sclk;
      logic [7:0] sr;
      logic [3:0] ctl;   // {addr_we, dm_we, sr_we, miso_buff} after the edge
      logic [2:0] st;    // state code after the edge
   } vec_t;

   vec_t vq[$];

   int total = 0;
   int bad   = 0;

   // Cycle monitor, updated on every observation.
   int cyc = 0;
   int n_addr, n_dm, n_sr, n_miso;
   int addr_cyc, dm_cyc, sr_cyc, miso_first, miso_last;
   logic [7:0] sr_v;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clr_mon();
      n_addr = 0; n_dm = 0; n_sr = 0; n_miso = 0;
      addr_cyc = -1; dm_cyc = -1; sr_cyc = -1; miso_first = -1; miso_last = -1;
   endtask

   // Drive one cycle of inputs, step past the rising edge and log what the DUT shows.
   task automatic run_cycle(input logic rst_n, input logic cs, input logic sclk,
                            input logic [7:0] sr);
      reset_n     = rst_n;
      cs_cond     = cs;
      sclk_pos    = sclk;
      shift_reg_p = sr;
      @(posedge clk);
      #1;
      cyc++;
      if (addr_we)   begin n_addr++; addr_cyc = cyc; end
      if (dm_we)     begin n_dm++;   dm_cyc   = cyc; end
      if (sr_we)     begin n_sr++;   sr_cyc   = cyc; end
      if (miso_buff) begin
         n_miso++;
         if (miso_first < 0) miso_first = cyc;
         miso_last = cyc;
      end
   endtask

   // Shift npulses bits of b MSB-first, pulses 8 clks apart; p_last is the final pulse's cycle.
   task automatic send_frame(input logic [7:0] b, input int npulses, input logic cs_last,
                             output int p_last);
      p_last = -1;
      for (int i = 0; i < npulses; i++) begin
         for (int k = 0; k < 7; k++) run_cycle(1'b1, 1'b0, 1'b0, sr_v);
         sr_v = {sr_v[6:0], b[7-i]};
         run_cycle(1'b1, (i == npulses - 1) ? cs_last : 1'b0, 1'b1, sr_v);
         p_last = cyc;
      end
   endtask

   task automatic chk_dbg(input string name, input logic [2:0] exp_st);
`ifdef SPI_FSM_DEBUG_EN
      chk(name, dbg_state, exp_st);
`else
      chk(name, dbg_state, 0);
`endif
   endtask

   task automatic push(input logic rst_n, input logic cs, input logic sclk,
                       input logic [7:0] sr, input logic [3:0] ctl, input logic [2:0] st);
      vec_t v;
      v.rst_n = rst_n; v.cs = cs; v.sclk = sclk; v.sr = sr; v.ctl = ctl; v.st = st;
      vq.push_back(v);
   endtask

   int p8, p16, pq;

   initial begin
      reset_n = 1'b0; cs_cond = 1'b1; sclk_pos = 1'b0; shift_reg_p = 8'h00; sr_v = 8'h00;
      clr_mon();

      // Write 0x2A / 0xA5 with back-to-back pulses; stray pulses in GOT_ADDR/COMMIT/DONE.
      push(1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 3'd0);
      push(1'b1, 1'b1, 1'b0, 8'h00, 4'b0000, 3'd0);
      push(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 3'd1);
      for (int i = 0; i < 7; i++) push(1'b1, 1'b0, 1'b1, 8'h2A, 4'b0000, 3'd1);
      push(1'b1, 1'b0, 1'b1, 8'h2A, 4'b1000, 3'd2);
      push(1'b1, 1'b0, 1'b1, 8'h2A, 4'b0000, 3'd5);
      for (int i = 0; i < 7; i++) push(1'b1, 1'b0, 1'b1, 8'hA5, 4'b0000, 3'd5);
      push(1'b1, 1'b0, 1'b1, 8'hA5, 4'b0100, 3'd6);
      push(1'b1, 1'b0, 1'b1, 8'hA5, 4'b0000, 3'd7);
      push(1'b1, 1'b0, 1'b1, 8'hA5, 4'b0000, 3'd7);
      push(1'b1, 1'b1, 1'b0, 8'hA5, 4'b0000, 3'd0);
      // Read 0x2B.
      push(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 3'd1);
      for (int i = 0; i < 7; i++) push(1'b1, 1'b0, 1'b1, 8'h2B, 4'b0000, 3'd1);
      push(1'b1, 1'b0, 1'b1, 8'h2B, 4'b1000, 3'd2);
      push(1'b1, 1'b0, 1'b0, 8'h2B, 4'b0011, 3'd3);
      push(1'b1, 1'b0, 1'b0, 8'h2B, 4'b0001, 3'd4);
      for (int i = 0; i < 7; i++) push(1'b1, 1'b0, 1'b1, 8'h55, 4'b0001, 3'd4);
      push(1'b1, 1'b0, 1'b1, 8'h55, 4'b0000, 3'd7);
      push(1'b1, 1'b1, 1'b0, 8'h55, 4'b0000, 3'd0);
      // Abort in GOT_ADDR wins over the read branch.
      push(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 3'd1);
      for (int i = 0; i < 7; i++) push(1'b1, 1'b0, 1'b1, 8'h2B, 4'b0000, 3'd1);
      push(1'b1, 1'b0, 1'b1, 8'h2B, 4'b1000, 3'd2);
      push(1'b1, 1'b1, 1'b0, 8'h2B, 4'b0000, 3'd0);
      push(1'b1, 1'b1, 1'b1, 8'h2B, 4'b0000, 3'd0);

      for (int i = 0; i < vq.size(); i++) begin
         run_cycle(vq[i].rst_n, vq[i].cs, vq[i].sclk, vq[i].sr);
         chk($sformatf("vec%0d ctl", i), {addr_we, dm_we, sr_we, miso_buff}, vq[i].ctl);
         chk_dbg($sformatf("vec%0d dbg", i), vq[i].st);
      end

      // Write with pulses 8 clks apart.
      clr_mon();
      sr_v = 8'h00;
      run_cycle(1'b1, 1'b0, 1'b0, sr_v);
      send_frame(8'h2A, 8, 1'b0, p8);
      send_frame(8'hA5, 8, 1'b0, p16);
      for (int k = 0; k < 4; k++) run_cycle(1'b1, 1'b0, 1'b0, sr_v);
      chk("wr addr_we count", n_addr, 1);
      chk("wr addr_we cycle", addr_cyc, p8);
      chk("wr dm_we count", n_dm, 1);
      chk("wr dm_we cycle", dm_cyc, p16);
      chk("wr miso count", n_miso, 0);
      chk_dbg("wr done hold", 3'd7);
      run_cycle(1'b1, 1'b1, 1'b0, sr_v);
      chk_dbg("wr idle", 3'd0);

      // Read with pulses 8 clks apart.
      clr_mon();
      run_cycle(1'b1, 1'b0, 1'b0, sr_v);
      send_frame(8'h2B, 8, 1'b0, p8);
      send_frame(8'h3C, 8, 1'b0, pq);
      run_cycle(1'b1, 1'b0, 1'b0, sr_v);
      chk("rd addr_we cycle", addr_cyc, p8);
      chk("rd sr_we count", n_sr, 1);
      chk("rd sr_we cycle", sr_cyc, p8 + 1);
      chk("rd miso first", miso_first, p8 + 1);
      chk("rd miso last", miso_last, pq - 1);
      chk("rd miso count", n_miso, pq - 1 - (p8 + 1) + 1);
      chk("rd dm_we count", n_dm, 0);
      run_cycle(1'b1, 1'b1, 1'b0, sr_v);

      // Abort after 12 pulses of a write.
      clr_mon();
      run_cycle(1'b1, 1'b0, 1'b0, sr_v);
      send_frame(8'h2A, 8, 1'b0, p8);
      send_frame(8'hA5, 4, 1'b0, pq);
      run_cycle(1'b1, 1'b1, 1'b0, sr_v);
      chk("abort ctl", {addr_we, dm_we, sr_we, miso_buff}, 0);
      chk_dbg("abort dbg", 3'd0);
      for (int k = 0; k < 8; k++) run_cycle(1'b1, 1'b1, k[0], sr_v);
      chk("abort dm_we count", n_dm, 0);

      // CS rises together with the final data pulse.
      clr_mon();
      run_cycle(1'b1, 1'b0, 1'b0, sr_v);
      send_frame(8'h2A, 8, 1'b0, p8);
      send_frame(8'hA5, 8, 1'b1, p16);
      chk_dbg("simul dbg", 3'd0);
      for (int k = 0; k < 4; k++) run_cycle(1'b1, 1'b1, 1'b0, sr_v);
      chk("simul addr_we count", n_addr, 1);
      chk("simul dm_we count", n_dm, 0);

      // Reset during READ_SHIFT, then a fresh write.
      clr_mon();
      run_cycle(1'b1, 1'b0, 1'b0, sr_v);
      send_frame(8'h2B, 8, 1'b0, p8);
      send_frame(8'h00, 3, 1'b0, pq);
      chk("rst pre miso", miso_buff, 1);
      run_cycle(1'b0, 1'b0, 1'b0, sr_v);
      chk("rst ctl", {addr_we, dm_we, sr_we, miso_buff}, 0);
      chk("rst dbg", dbg_state, 0);
      run_cycle(1'b1, 1'b1, 1'b0, sr_v);
      clr_mon();
      run_cycle(1'b1, 1'b0, 1'b0, sr_v);
      send_frame(8'h2A, 8, 1'b0, p8);
      send_frame(8'hA5, 8, 1'b0, p16);
      run_cycle(1'b1, 1'b0, 1'b0, sr_v);
      chk("rst wr addr_we cycle", addr_cyc, p8);
      chk("rst wr dm_we count", n_dm, 1);
      chk("rst wr dm_we cycle", dm_cyc, p16);
      run_cycle(1'b1, 1'b1, 1'b0, sr_v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
